// File: rtl/ladybird_bus_router.sv
// ladybird_bus_router: routes one bus master to NUM_TARGET slaves by address tag
// and returns responses in request order. Revision 1.0
`default_nettype none

module ladybird_bus_router #(
  parameter int                          XLEN            = 32,
  parameter int                          NUM_TARGET      = 6,
  parameter int                          TAG_MSB         = XLEN - 1,
  parameter int                          TAG_W           = 4,
  parameter logic [NUM_TARGET*TAG_W-1:0] TAG_TABLE       = 24'hEDF089,
  parameter int                          DEFAULT_TARGET  = 2,
  parameter logic [NUM_TARGET-1:0]       ENABLE_MASK     = 6'b111111,
  parameter int                          MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_req_valid,
  output logic                               o_req_ready,
  input  logic [XLEN-1:0]                    i_req_addr,
  input  logic                               i_req_we,
  input  logic [XLEN/8-1:0]                  i_req_wstrb,
  input  logic [XLEN-1:0]                    i_req_wdata,
  output logic                               o_resp_valid,
  input  logic                               i_resp_ready,
  output logic [XLEN-1:0]                    o_resp_rdata,
  output logic                               o_resp_err,
  output logic [NUM_TARGET-1:0]              o_tgt_req_valid,
  input  logic [NUM_TARGET-1:0]              i_tgt_req_ready,
  output logic [XLEN-1:0]                    o_tgt_req_addr,
  output logic [XLEN-1:0]                    o_tgt_req_wdata,
  output logic                               o_tgt_req_we,
  output logic [XLEN/8-1:0]                  o_tgt_req_wstrb,
  input  logic [NUM_TARGET-1:0]              i_tgt_resp_valid,
  output logic [NUM_TARGET-1:0]              o_tgt_resp_ready,
  input  logic [NUM_TARGET*XLEN-1:0]         i_tgt_resp_rdata,
  output logic [$clog2(MAX_OUTSTANDING):0]   o_outstanding,
  output logic                               o_idle
);

  localparam int c_id_w  = $clog2(NUM_TARGET + 1);
  localparam int c_ptr_w = $clog2(MAX_OUTSTANDING);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [c_id_w-1:0] c_err_id = c_id_w'(NUM_TARGET);

  logic [c_id_w-1:0]  r_fifo [MAX_OUTSTANDING];
  logic [c_ptr_w-1:0] r_wptr;
  logic [c_ptr_w-1:0] r_rptr;
  logic [c_cnt_w-1:0] r_count;

  logic [TAG_W-1:0]   w_tag;
  logic [c_id_w-1:0]  w_sel;
  logic               w_hit;
  logic               w_sel_en;
  logic [c_id_w-1:0]  w_id;
  logic               w_full;
  logic               w_empty;
  logic               w_tgt_rdy;
  logic [c_id_w-1:0]  w_head;
  logic               w_push;
  logic               w_pop;

  assign w_tag = i_req_addr[TAG_MSB -: TAG_W];

  // Lowest matching index wins; the hit flag stops later entries overriding it.
  always_comb begin
    w_sel = c_id_w'(DEFAULT_TARGET);
    w_hit = 1'b0;
    for (int i = 0; i < NUM_TARGET; i++) begin
      if (!w_hit && (TAG_TABLE[i*TAG_W +: TAG_W] == w_tag)) begin
        w_sel = c_id_w'(i);
        w_hit = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_en = 1'b0;
    for (int i = 0; i < NUM_TARGET; i++) begin
      if (w_sel == c_id_w'(i)) w_sel_en = ENABLE_MASK[i];
    end
  end

  assign w_id    = w_sel_en ? w_sel : c_err_id;
  assign w_full  = (r_count == c_cnt_w'(MAX_OUTSTANDING));
  assign w_empty = (r_count == '0);

  always_comb begin
    o_tgt_req_valid = '0;
    w_tgt_rdy       = 1'b0;
    for (int i = 0; i < NUM_TARGET; i++) begin
      if (w_id == c_id_w'(i)) begin
        w_tgt_rdy          = i_tgt_req_ready[i];
        o_tgt_req_valid[i] = i_req_valid & ~w_full & ~reset;
      end
    end
  end

  // Full uses the pre-pop count so resp_ready never reaches req_ready.
  assign o_req_ready = ~reset & ~w_full & ((w_id == c_err_id) | w_tgt_rdy);

  assign o_tgt_req_addr  = i_req_addr;
  assign o_tgt_req_wdata = i_req_wdata;
  assign o_tgt_req_we    = i_req_we;
  assign o_tgt_req_wstrb = i_req_wstrb;

  assign w_head = r_fifo[r_rptr];

  always_comb begin
    o_resp_valid     = 1'b0;
    o_resp_rdata     = '0;
    o_resp_err       = 1'b0;
    o_tgt_resp_ready = '0;
    if (!w_empty) begin
      if (w_head == c_err_id) begin
        o_resp_valid = 1'b1;
        o_resp_err   = 1'b1;
      end else begin
        for (int i = 0; i < NUM_TARGET; i++) begin
          if (w_head == c_id_w'(i)) begin
            o_resp_valid        = i_tgt_resp_valid[i];
            o_resp_rdata        = i_tgt_resp_rdata[i*XLEN +: XLEN];
            o_tgt_resp_ready[i] = i_resp_ready;
          end
        end
      end
    end
  end

  assign w_push = i_req_valid & o_req_ready;
  assign w_pop  = o_resp_valid & i_resp_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + c_ptr_w'(1);
      if (w_pop)  r_rptr <= r_rptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot contents are only read while occupied, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wptr] <= w_id;
  end

  assign o_outstanding = r_count;
  assign o_idle        = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_ladybird_bus_router.sv
// tb_ladybird_bus_router: randomized bench with an in-order scoreboard and target models.
`default_nettype none

module tb_ladybird_bus_router;

  localparam int          NT    = 6;
  localparam logic [23:0] TABLE = 24'hEDF089;
  localparam logic [5:0]  MASK  = 6'b110111;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           i_req_valid = 1'b0;
  logic [31:0]    i_req_addr = '0;
  logic           i_req_we = 1'b0;
  logic [3:0]     i_req_wstrb = '0;
  logic [31:0]    i_req_wdata = '0;
  logic           i_resp_ready = 1'b0;
  logic [NT-1:0]  i_tgt_req_ready = '0;
  logic [NT-1:0]  i_tgt_resp_valid = '0;
  logic [NT*32-1:0] i_tgt_resp_rdata = '0;

  logic           o_req_ready, o_resp_valid, o_resp_err, o_tgt_req_we, o_idle;
  logic [31:0]    o_resp_rdata, o_tgt_req_addr, o_tgt_req_wdata;
  logic [3:0]     o_tgt_req_wstrb;
  logic [NT-1:0]  o_tgt_req_valid, o_tgt_resp_ready;
  logic [2:0]     o_outstanding;

  ladybird_bus_router #(.ENABLE_MASK(MASK), .MAX_OUTSTANDING(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_we(i_req_we),
    .i_req_wstrb(i_req_wstrb), .i_req_wdata(i_req_wdata),
    .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err),
    .o_tgt_req_valid(o_tgt_req_valid), .i_tgt_req_ready(i_tgt_req_ready),
    .o_tgt_req_addr(o_tgt_req_addr), .o_tgt_req_wdata(o_tgt_req_wdata),
    .o_tgt_req_we(o_tgt_req_we), .o_tgt_req_wstrb(o_tgt_req_wstrb),
    .i_tgt_resp_valid(i_tgt_resp_valid), .o_tgt_resp_ready(o_tgt_resp_ready),
    .i_tgt_resp_rdata(i_tgt_resp_rdata),
    .o_outstanding(o_outstanding), .o_idle(o_idle)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat [NT];
  logic [31:0] tq_data [NT][$];
  int          tq_time [NT][$];
  int          mq [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Target number for an address, or NT when the region is disabled.
  function automatic int ref_route(input logic [31:0] a);
    int tag;
    int t;
    tag = int'(a[31:28]);
    t = 2;
    for (int i = NT - 1; i >= 0; i--)
      if (int'((TABLE >> (4 * i)) & 24'hF) == tag) t = i;
    if (((MASK >> t) & 6'b1) == 6'b0) return NT;
    return t;
  endfunction

  task automatic cycle();
    int id, h;
    bit full, exp_rr, exp_rv, exp_err;
    logic [NT-1:0] exp_tv, exp_trr;
    logic [31:0] exp_rd;
    h = NT; id = NT; exp_rr = 0; exp_rv = 0;
    for (int i = 0; i < NT; i++) begin
      i_tgt_resp_valid[i] = (tq_data[i].size() > 0) && (tq_time[i][0] <= cyc);
      i_tgt_resp_rdata[i*32 +: 32] = i_tgt_resp_valid[i] ? tq_data[i][0] : $urandom;
    end
    i_req_we = 1'($urandom); i_req_wstrb = 4'($urandom); i_req_wdata = $urandom;
    #2;
    if (!reset) begin
      id = ref_route(i_req_addr);
      full = (mq.size() == DEPTH);
      exp_rr = !full && (id == NT || i_tgt_req_ready[id]);
      exp_tv = '0;
      if (id != NT && !full && i_req_valid) exp_tv[id] = 1'b1;
      exp_rd = '0; exp_err = 0; exp_trr = '0;
      if (mq.size() > 0) begin
        h = mq[0];
        if (h == NT) begin
          exp_rv = 1; exp_err = 1;
        end else begin
          exp_rv = i_tgt_resp_valid[h];
          if (exp_rv) exp_rd = tq_data[h][0];
          exp_trr[h] = i_resp_ready;
        end
      end
      check_eq("req_ready", 64'(o_req_ready), 64'(exp_rr));
      check_eq("tgt_req_valid", 64'(o_tgt_req_valid), 64'(exp_tv));
      check_eq("resp_valid", 64'(o_resp_valid), 64'(exp_rv));
      check_eq("tgt_resp_ready", 64'(o_tgt_resp_ready), 64'(exp_trr));
      check_eq("outstanding", 64'(o_outstanding), 64'(mq.size()));
      check_eq("idle", 64'(o_idle), 64'(mq.size() == 0));
      check_eq("addr_bcast", 64'(o_tgt_req_addr), 64'(i_req_addr));
      if (exp_rv || mq.size() == 0) begin
        check_eq("resp_rdata", 64'(o_resp_rdata), 64'(exp_rd));
        check_eq("resp_err", 64'(o_resp_err), 64'(exp_err));
      end
    end
    @(posedge clk); #1;
    cyc++;
    if (reset) begin
      mq.delete();
      for (int i = 0; i < NT; i++) begin
        tq_data[i].delete(); tq_time[i].delete();
      end
    end else begin
      if (exp_rv && i_resp_ready) begin
        if (h != NT) begin
          void'(tq_data[h].pop_front()); void'(tq_time[h].pop_front());
        end
        void'(mq.pop_front());
      end
      if (i_req_valid && exp_rr) begin
        mq.push_back(id);
        if (id != NT) begin
          tq_data[id].push_back($urandom);
          tq_time[id].push_back(cyc + (lat[id] < 0 ? int'($urandom_range(0, 4)) : lat[id]));
        end
      end
    end
  endtask

  task automatic drain(input int n);
    i_req_valid = 0; i_resp_ready = 1;
    repeat (n) cycle();
    check_eq("drained", 64'(o_outstanding), 64'(0));
  endtask

  initial begin
    for (int i = 0; i < NT; i++) lat[i] = 0;
    i_tgt_req_ready = '1;
    @(posedge clk); #1;
    cycle(); cycle();
    reset = 0;
    check_eq("rst_outstanding", 64'(o_outstanding), 64'(0));
    check_eq("rst_idle", 64'(o_idle), 64'(1));
    check_eq("rst_resp_valid", 64'(o_resp_valid), 64'(0));

    // Target 0 then a disabled region (tag F), then a no-match address to DRAM.
    i_resp_ready = 1; i_req_valid = 1;
    i_req_addr = 32'h9000_0010; cycle();
    i_req_addr = 32'hF000_0000; cycle();
    i_req_addr = 32'h4000_0000; cycle();
    drain(5);

    // Slow target 0 ahead of fast target 1: target 1 must wait.
    lat[0] = 4; lat[1] = 0;
    i_req_valid = 1;
    i_req_addr = 32'h9000_0000; cycle();
    i_req_addr = 32'h8000_0000; cycle();
    drain(8);
    lat[0] = 0;

    // Fill the order FIFO, then pop and push together.
    i_resp_ready = 0; i_req_valid = 1; i_req_addr = 32'h0000_0040;
    repeat (5) cycle();
    check_eq("fill_outstanding", 64'(o_outstanding), 64'(4));
    i_resp_ready = 1; cycle();
    cycle();
    drain(8);

    // Reset with requests in flight.
    i_resp_ready = 0; i_req_valid = 1; i_req_addr = 32'hD000_0000;
    repeat (3) cycle();
    check_eq("pre_reset_outstanding", 64'(o_outstanding), 64'(3));
    reset = 1; cycle();
    reset = 0; cycle();
    check_eq("post_reset_outstanding", 64'(o_outstanding), 64'(1));
    drain(6);

    for (int i = 0; i < NT; i++) lat[i] = -1;
    repeat (2000) begin
      i_req_valid = ($urandom_range(0, 9) < 6);
      i_req_addr = {4'($urandom_range(0, 15)), 28'($urandom)};
      i_resp_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < NT; i++) i_tgt_req_ready[i] = ($urandom_range(0, 3) != 0);
      cycle();
    end
    i_tgt_req_ready = '1;
    drain(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ladybird_bus_router.md
Name: ladybird_bus_router

Overview:
- Parametrised address-decode router between one core bus master (I_BUS or D_BUS port) and NUM_TARGET peripheral slaves (IRAM/BRAM/DRAM/UART/QSPI/GPIO by default).
- Decodes a programmable address tag field and forwards each request to exactly one target.
- Tracks up to MAX_OUTSTANDING in-flight requests in an order FIFO and returns responses to the master strictly in request order.
- Requests to disabled regions are not forwarded; the router answers them internally with a bus error.

Parameters:
- XLEN, 32, address and data width.
- NUM_TARGET, 6, number of downstream slave channels.
- TAG_MSB, XLEN-1, MSB of the decoded address field.
- TAG_W, 4, width of the decoded field, addr[TAG_MSB -: TAG_W].
- TAG_TABLE, 24'hEDF089, packed NUM_TARGET*TAG_W. Entry i at [i*TAG_W +: TAG_W] is the tag of target i.
- DEFAULT_TARGET, 2, target chosen when no tag matches (DRAM).
- ENABLE_MASK, 6'b111111, bit i=0 makes target i unreachable (error response).
- MAX_OUTSTANDING, 4, order FIFO depth, power of two, ≥2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid / req_ready  in / out  1 / 1  master request handshake.
- req_addr  in  XLEN  request address.
- req_we  in  1  write enable.
- req_wstrb  in  XLEN/8  write byte strobes.
- req_wdata  in  XLEN  write data.
- resp_valid / resp_ready  out / in  1 / 1  master response handshake.
- resp_rdata  out  XLEN  read data.
- resp_err  out  1  error response flag.
- tgt_req_valid / tgt_req_ready  out / in  NUM_TARGET / NUM_TARGET  per-target request handshake.
- tgt_req_addr, tgt_req_wdata  out  XLEN  broadcast copies of req_addr / req_wdata.
- tgt_req_we, tgt_req_wstrb  out  1, XLEN/8  broadcast copies of req_we / req_wstrb.
- tgt_resp_valid / tgt_resp_ready  in / out  NUM_TARGET / NUM_TARGET  per-target response handshake.
- tgt_resp_rdata  in  NUM_TARGET*XLEN  per-target read data, target i at [i*XLEN +: XLEN].
- outstanding  out  $clog2(MAX_OUTSTANDING)+1  current FIFO occupancy.
- idle  out  1  high when outstanding==0.

Behaviour:
- Decode is combinational. sel = lowest index i with TAG_TABLE entry == addr field; if none, DEFAULT_TARGET.
- id = sel if ENABLE_MASK[sel]=1, else ERR (encoded value NUM_TARGET). id width is $clog2(NUM_TARGET+1).
- Request accept:
  - id≠ERR: req_ready = !full & tgt_req_ready[id]; tgt_req_valid[id] = req_valid & !full; all other tgt_req_valid bits are 0.
  - id==ERR: req_ready = !full; no tgt_req_valid is raised.
  - A pop in the same cycle does NOT free a slot for a push: full is evaluated on the pre-pop count.
- Push: on req_valid&req_ready, push id into the order FIFO. Requests are zero-wait; a burst of back-to-back requests is accepted one per cycle.
- Response, head id = h, FIFO non-empty:
  - h≠ERR: resp_valid = tgt_resp_valid[h]; resp_rdata = slot h of tgt_resp_rdata; resp_err=0; tgt_resp_ready[h] = resp_ready.
  - h==ERR: resp_valid=1 (from registered state only); resp_rdata=0; resp_err=1.
  - All non-head tgt_resp_ready bits are 0. A non-head target holding a response is stalled, never dropped or reordered.
- Empty FIFO: resp_valid=0, tgt_resp_ready=0, resp_rdata=0, resp_err=0.
- Pop on resp_valid&resp_ready. Simultaneous push and pop leaves outstanding unchanged.
- FIFO pointers wrap modulo MAX_OUTSTANDING. Count saturates structurally: push is blocked at full, pop is impossible at empty.
- Reset (synchronous, any cycle including mid-transaction):
  - Pointers and count clear to 0; outstanding=0, idle=1, all valid/ready outputs 0.
  - In-flight transactions are abandoned. Targets must be reset in the same cycle.
- Combinational paths allowed: req_addr→req_ready / tgt_req_valid; tgt_resp_*→resp_*. No path resp_ready→req_ready.

Test Plan:
- Default table; read 0x9000_0010 then 0xF000_0000, all targets ready, 1-cycle responses → tgt_req_valid[0] then tgt_req_valid[3]; responses returned in order; outstanding peaks at 1-2 and returns to 0; idle=1.
- Read 0x4000_0000 (no tag match) → routed to target 2 (DRAM); rdata passes through unchanged (0x1234_5678).
- ENABLE_MASK=6'b110111; read 0xF000_0004 → no tgt_req_valid; next cycle resp_valid=1, resp_err=1, rdata=0.
- Reordering: issue to target 0 (slow, 5 cycles) then target 1 (responds after 1 cycle) → target 1 held with tgt_resp_ready[1]=0 until target 0's response pops; master sees target 0 data first.
- Fill: 4 accepted requests with no responses → outstanding=4, req_ready=0. Pop and push in the same cycle → push refused that cycle, accepted the next.
- Assert reset with outstanding=3 → next cycle outstanding=0, idle=1, resp_valid=0; a new request is accepted immediately.
